// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time byte-stream program loader for instruction memory
//
// Receives LEN_LO, LEN_HI, 4*N payload bytes and a CSUM byte over a
// valid/ready byte stream. It assembles little-endian 32-bit words, writes them
// to instruction memory, and releases the core reset only after the checksum matches.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   byte_valid/data      upstream byte stream
//   byte_ready           loader accepts a byte (decoded from state only)
//   imem_we/addr/wdata   registered one-cycle instruction memory write
//   core_rst_n           core reset, high once a clean image is loaded
//   load_done, load_err  sticky status flags
module prog_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rst_n,
   output logic        load_done,
   output logic        load_err
);

   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

   // Word count that exactly fills memory. N equal to this value is legal.
   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

   state_t                state;
   logic [7:0]            len_lo;
   logic [15:0]           len;
   logic [7:0]            csum;
   logic [1:0]            lane;
   logic [ADDR_WIDTH:0]   idx;
   logic [23:0]           word_buf;

   logic                  xfer;
   logic [15:0]           n_in;
   logic [16:0]           idx_next;

   assign byte_ready = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
   assign xfer       = byte_valid & byte_ready;
   assign n_in       = {byte_data, len_lo};
   assign idx_next   = 17'(idx) + 17'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_LEN0;
         len_lo     <= 8'd0;
         len        <= 16'd0;
         csum       <= 8'd0;
         lane       <= 2'd0;
         idx        <= '0;
         word_buf   <= 24'd0;
         imem_we    <= 1'b0;
         imem_addr  <= 32'd0;
         imem_wdata <= 32'd0;
         core_rst_n <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (xfer) begin
            case (state)
               S_LEN0: begin
                  len_lo <= byte_data;
                  state  <= S_LEN1;
               end
               S_LEN1: begin
                  len <= n_in;
                  if ({1'b0, n_in} > MAX_WORDS) begin
                     state    <= S_ERR;
                     load_err <= 1'b1;
                  end else if (n_in == 16'd0) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  csum <= csum + byte_data;
                  lane <= lane + 2'd1;
                  case (lane)
                     2'd0: word_buf[7:0]   <= byte_data;
                     2'd1: word_buf[15:8]  <= byte_data;
                     2'd2: word_buf[23:16] <= byte_data;
                     default: begin
                        // Fourth lane completes the word; the write goes out
                        // registered while the next word's bytes keep arriving.
                        imem_we    <= 1'b1;
                        imem_wdata <= {byte_data, word_buf};
                        imem_addr  <= {{(29 - ADDR_WIDTH){1'b0}}, idx, 2'b00};
                        idx        <= idx + 1'b1;
                        if (idx_next == {1'b0, len}) begin
                           state <= S_CSUM;
                        end
                     end
                  endcase
               end
               S_CSUM: begin
                  if (byte_data == csum) begin
                     state      <= S_RUN;
                     core_rst_n <= 1'b1;
                     load_done  <= 1'b1;
                  end else begin
                     state    <= S_ERR;
                     load_err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
